// File: rtl/sha_req_queue_if.sv
// rtl/sha_req_queue_if.sv - host byte stream and FSM request handshake bundle
interface sha_req_queue_if #(
  parameter int ADDRW = 24
);
  localparam int IW = 3 * ADDRW + 2;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          req_valid;
  logic [IW-1:0] req_data;
  logic          ready_req_in;

  modport master (
    output in_valid, in_data, ready_req_in,
    input  in_ready, req_valid, req_data
  );

  modport slave (
    input  in_valid, in_data, ready_req_in,
    output in_ready, req_valid, req_data
  );
endinterface

// File: rtl/sha_req_queue.sv
// rtl/sha_req_queue.sv - byte-stream instruction assembler feeding a FWFT request FIFO
module sha_req_queue #(
  parameter int ADDRW = 24,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  sha_req_queue_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy
);
  localparam int IW   = 3 * ADDRW + 2;
  localparam int NB   = (IW + 7) / 8;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int BCW  = $clog2(NB);
  localparam int LOW  = 8 * (NB - 1);
  localparam int TOPB = IW - LOW;

  logic [BCW-1:0] byte_cnt;
  logic [LOW-1:0] asm_q;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [IW-1:0]  mem [DEPTH];

  logic           last_byte;
  logic           full;
  logic           accept;
  logic           push;
  logic           pop;
  logic [IW-1:0]  push_word;

  assign last_byte = (byte_cnt == BCW'(NB - 1));
  assign full      = (count == CW'(DEPTH));

  // Only the completing byte is throttled by a full queue; ready_req_in is deliberately not used here.
  assign bus.in_ready = !rst && (!last_byte || !full || flush);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && !flush && last_byte;
  assign pop          = bus.req_valid && bus.ready_req_in && !flush;

  // The final byte goes straight into the pushed word; its bits above IW-1 are dropped.
  assign push_word = {bus.in_data[TOPB-1:0], asm_q};

  assign bus.req_valid = (count != '0);
  assign bus.req_data  = mem[rd_ptr];
  assign level         = count;
  assign busy          = (byte_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      byte_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (accept) begin
        if (last_byte) begin
          byte_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          asm_q[int'(byte_cnt) * 8 +: 8] <= bus.in_data;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end
endmodule

// File: tb/tb_sha_req_queue.sv
// tb/tb_sha_req_queue.sv - directed self-checking bench for sha_req_queue
module tb_sha_req_queue;
  localparam int ADDRW = 24;
  localparam int DEPTH = 4;
  localparam int IW    = 3 * ADDRW + 2;
  localparam int NB    = (IW + 7) / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] level;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  sha_req_queue_if #(.ADDRW(ADDRW)) bus ();

  sha_req_queue #(.ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave),
    .level (level),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(input logic [1:0] c, input logic [23:0] k,
                                       input logic [23:0] t, input logic [23:0] d);
    return {c, k, t, d};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [IW-1:0] w, input int k);
    logic [8*NB-1:0] w_ext;
    w_ext = {{(8*NB-IW){1'b0}}, w};
    return w_ext[8*k +: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("byte_accept", {127'b0, bus.in_ready}, 128'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [IW-1:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) send_byte(byte_of(w, k));
  endtask

  task automatic pop_one();
    bus.ready_req_in = 1'b1;
    tick();
    bus.ready_req_in = 1'b0;
  endtask

  logic [IW-1:0] w_basic;
  logic [IW-1:0] w_a;
  logic [IW-1:0] w_b;
  logic [IW-1:0] w_c;
  logic [IW-1:0] sb[$];
  logic [IW-1:0] exp_w;

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = 8'h00;
    bus.ready_req_in = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
    chk("rst_req_valid", {127'b0, bus.req_valid}, 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_level", {125'b0, level}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_in_ready_after", {127'b0, bus.in_ready}, 128'd1);

    // basic assembly
    w_basic = {2'b10, 24'h000100, 24'h000200, 24'h000300};
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    chk("basic_busy_9", {127'b0, busy}, 128'd1);
    chk("basic_valid_9", {127'b0, bus.req_valid}, 128'd0);
    send_byte(8'h02);
    chk("basic_valid", {127'b0, bus.req_valid}, 128'd1);
    chk("basic_data", {54'b0, bus.req_data}, {54'b0, w_basic});
    chk("basic_level", {125'b0, level}, 128'd1);
    chk("basic_busy", {127'b0, busy}, 128'd0);
    pop_one();
    chk("basic_pop_valid", {127'b0, bus.req_valid}, 128'd0);
    chk("basic_pop_level", {125'b0, level}, 128'd0);

    // full FIFO stall on final byte
    for (int i = 1; i <= 4; i++) send_bytes(mk(2'b00, 24'h0, 24'h0, 24'(i)), 0, NB - 1);
    chk("full_level", {125'b0, level}, 128'd4);
    w_c = mk(2'b00, 24'h0, 24'h0, 24'd5);
    send_bytes(w_c, 0, NB - 2);
    chk("full_in_ready_0", {127'b0, bus.in_ready}, 128'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = byte_of(w_c, NB - 1);
    tick();
    chk("full_stall_ready", {127'b0, bus.in_ready}, 128'd0);
    chk("full_stall_level", {125'b0, level}, 128'd4);
    chk("full_stall_busy", {127'b0, busy}, 128'd1);
    bus.ready_req_in = 1'b1;
    tick();
    bus.ready_req_in = 1'b0;
    chk("full_pop_level", {125'b0, level}, 128'd3);
    chk("full_pop_ready", {127'b0, bus.in_ready}, 128'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("full_refill_level", {125'b0, level}, 128'd4);
    chk("full_refill_busy", {127'b0, busy}, 128'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("full_drain_order", {54'b0, bus.req_data}, {54'b0, mk(2'b00, 24'h0, 24'h0, 24'(i))});
      pop_one();
    end
    chk("full_drain_empty", {127'b0, bus.req_valid}, 128'd0);

    // simultaneous push and pop
    w_a = mk(2'b01, 24'hAAAAAA, 24'h111111, 24'h00000A);
    w_b = mk(2'b10, 24'hBBBBBB, 24'h222222, 24'h00000B);
    w_c = mk(2'b11, 24'hCCCCCC, 24'h333333, 24'h00000C);
    send_bytes(w_a, 0, NB - 1);
    send_bytes(w_b, 0, NB - 1);
    send_bytes(w_c, 0, NB - 2);
    chk("pp_level_pre", {125'b0, level}, 128'd2);
    bus.in_valid     = 1'b1;
    bus.in_data      = byte_of(w_c, NB - 1);
    bus.ready_req_in = 1'b1;
    chk("pp_in_ready", {127'b0, bus.in_ready}, 128'd1);
    tick();
    bus.in_valid     = 1'b0;
    bus.ready_req_in = 1'b0;
    chk("pp_level", {125'b0, level}, 128'd2);
    chk("pp_head_b", {54'b0, bus.req_data}, {54'b0, w_b});
    pop_one();
    chk("pp_head_c", {54'b0, bus.req_data}, {54'b0, w_c});
    pop_one();
    chk("pp_empty", {125'b0, level}, 128'd0);

    // wrap-around with interleaved traffic
    for (int i = 0; i < 10; i++) begin
      exp_w = mk(2'(i), 24'hA00000 + 24'(i), 24'h0B0000 ^ 24'(i * 7), 24'h123456 + 24'(i) * 24'h010101);
      sb.push_back(exp_w);
      send_bytes(exp_w, 0, NB - 1);
      if (i % 2 == 1) begin
        chk("wrap_level", {125'b0, level}, 128'd2);
        for (int j = 0; j < 2; j++) begin
          exp_w = sb.pop_front();
          chk("wrap_data", {54'b0, bus.req_data}, {54'b0, exp_w});
          pop_one();
        end
      end
    end
    chk("wrap_empty", {127'b0, bus.req_valid}, 128'd0);

    // flush
    for (int i = 0; i < 3; i++) send_bytes(mk(2'b01, 24'h0, 24'h0, 24'(i + 7)), 0, NB - 1);
    w_a = mk(2'b11, 24'h5A5A5A, 24'hA5A5A5, 24'h0F0F0F);
    send_bytes(w_a, 0, 4);
    chk("flush_pre_level", {125'b0, level}, 128'd3);
    chk("flush_pre_busy", {127'b0, busy}, 128'd1);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    chk("flush_in_ready", {127'b0, bus.in_ready}, 128'd1);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_level", {125'b0, level}, 128'd0);
    chk("flush_valid", {127'b0, bus.req_valid}, 128'd0);
    chk("flush_busy", {127'b0, busy}, 128'd0);
    w_b = mk(2'b10, 24'h010203, 24'h040506, 24'h070809);
    send_bytes(w_b, 0, NB - 1);
    chk("flush_after_data", {54'b0, bus.req_data}, {54'b0, w_b});
    pop_one();

    // asynchronous reset mid-instruction
    send_bytes(w_a, 0, NB - 1);
    send_bytes(w_b, 0, NB - 1);
    send_bytes(w_c, 0, 3);
    chk("arst_pre_level", {125'b0, level}, 128'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {127'b0, bus.req_valid}, 128'd0);
    chk("arst_in_ready", {127'b0, bus.in_ready}, 128'd0);
    chk("arst_busy", {127'b0, busy}, 128'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", {127'b0, bus.in_ready}, 128'd1);
    chk("arst_rel_level", {125'b0, level}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
